acc_seq_ctrl: RTL and testbench
===============================

Name: acc_seq_ctrl

Overview:
- Command sequencer for the 8-bit accumulator datapath (reg8 accumulator register plus ALU).
- Accepts one command at a time over a valid/ready handshake.
- Drives the ALU opcode and operand, waits out the ALU latency, then pulses the accumulator load or clear strobe.
- Repeats the operation N times when requested, then reports completion with result and flags.

Parameters:
WIDTH, 8, datapath width of operand, ALU result and accumulator.
ALU_WAIT, 1, cycles spent in EXEC before the write; legal range 1..15.
RPT_W, 4, width of the repeat-count field.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command.
cmd_op  in  3  opcode: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 CLR.
cmd_data  in  WIDTH  operand.
cmd_repeat  in  RPT_W  iteration count; 0 is treated as 1.
alu_op  out  3  registered opcode to the ALU.
alu_opnd  out  WIDTH  registered operand to the ALU.
alu_result  in  WIDTH  ALU output; ALU computes acc OP opnd, and LDI passes the operand through.
alu_carry  in  1  ALU carry/borrow out.
acc_load  out  1  one-cycle load strobe to the accumulator register.
acc_clear  out  1  one-cycle clear strobe to the accumulator register.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle completion pulse.
result  out  WIDTH  last written accumulator value.
zero  out  1  result == 0.
carry  out  1  sticky carry over all iterations of the last command.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including cmd_ready, result, zero and carry.
  - An in-flight command is abandoned without any load strobe.
- cmd_ready is registered and rises on the first rising edge after reset=1.
  - It equals "next state is IDLE".
- Handshake:
  - A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
  - cmd_op, cmd_data and cmd_repeat are captured on that edge; later changes to them are ignored.
  - cmd_valid while busy is ignored and has no side effects.
- States: IDLE, EXEC, WRITE, DONE.
  - IDLE: accept a command.
    - NOP goes to DONE.
    - Any other opcode goes to EXEC and loads the remaining-count register with max(cmd_repeat,1) and the wait counter with ALU_WAIT.
    - carry is cleared on accept.
  - EXEC: alu_op and alu_opnd hold the captured values. The wait counter decrements each cycle; when it reaches 1, the next state is WRITE.
  - WRITE: lasts exactly one cycle.
    - CLR asserts acc_clear and captures result=0, zero=1, carry=0.
    - Every other opcode asserts acc_load, captures result=alu_result and zero=(alu_result==0), and sets carry |= alu_carry (ADD/SUB only; logic ops and LDI leave carry 0).
    - If remaining > 1: decrement remaining, reload the wait counter, go to EXEC.
    - Otherwise go to DONE.
  - DONE: done=1 for one cycle, then IDLE. result, zero and carry hold until the next WRITE or reset.
- Latency, with handshake on edge E, ALU_WAIT=1, repeat=1:
  - EXEC in cycle E+1.
  - acc_load high in cycle E+2.
  - done in cycle E+3.
  - cmd_ready high again in cycle E+4.
- Each extra iteration adds ALU_WAIT+1 cycles.
- NOP: done in cycle E+1, no strobes.
- acc_load and acc_clear are never both high and are never high outside WRITE.
- Arithmetic wraps modulo 2^WIDTH inside the ALU; the controller does no arithmetic on data.

Test Plan:
- Reset held low for 35 ns mid-EXEC of an ADD: no acc_load ever pulses; all outputs are 0; cmd_ready rises on the first edge after release.
- LDI data=0x05, repeat=1: acc_load pulses exactly once, 2 cycles after accept; done 1 cycle later; result=0x05, zero=0, carry=0.
- acc=0x05, ADD data=0x03, repeat=4, ALU model adds: 4 acc_load pulses spaced 2 cycles apart; result=0x11; done 9 cycles after accept.
- acc=0xF0, ADD 0x20 then SUB 0x10: first command gives result=0x10, carry=1. Second command shows carry cleared on accept, then result=0x00, zero=1, carry=0 (ALU model: carry is borrow, 0 here).
- CLR with ALU_WAIT=3: acc_clear is high for exactly one cycle, 4 cycles after accept; acc_load stays 0; result=0, zero=1.
- Back-to-back: cmd_valid held high with 3 queued commands (NOP, LDI 0x7F, XOR 0xFF). Exactly 3 accepts, each only when cmd_ready=1. Final result=0x80. Inputs changed during busy have no effect.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
`timescale 1ns/1ps
// acc_seq_ctrl: command sequencer for the 8-bit accumulator datapath.
// Takes one command over valid/ready, presents opcode and operand to the ALU,
// waits out the ALU latency, strobes the accumulator, repeats N times, then
// reports completion with the last written value and flags.
//
// state   | meaning
// S_IDLE  | cmd_ready high, waiting for a command
// S_EXEC  | captured opcode/operand on the ALU, waiting ALU_WAIT cycles
// S_WRITE | one cycle: acc_load or acc_clear strobe, result/flags captured
// S_DONE  | one cycle: done pulse, then back to S_IDLE
module acc_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int ALU_WAIT = 1,
  parameter int RPT_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [RPT_W-1:0] cmd_repeat,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_opnd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             acc_load,
  output logic             acc_clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDI = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_CLR = 3'd7
  } op_e;

  // Wait counter is 4 bits wide, enough for the full 1..15 ALU latency range.
  localparam logic [3:0]       WAIT_INIT = 4'(ALU_WAIT);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [RPT_W-1:0]   remain_q, remain_d;
  logic [3:0]         wait_q, wait_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               acc_load_q, acc_load_d;
  logic               acc_clear_q, acc_clear_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               accept;

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    remain_d    = remain_q;
    wait_d      = wait_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    accept      = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_e'(cmd_op);
          opnd_d  = cmd_data;
          carry_d = 1'b0;
          if (op_e'(cmd_op) == OP_NOP) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_EXEC;
            remain_d = (cmd_repeat == '0) ? RPT_ONE : cmd_repeat;
            wait_d   = WAIT_INIT;
          end
        end
      end
      S_EXEC: begin
        if (wait_q <= 4'd1) begin
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_WRITE: begin
        if (op_q == OP_CLR) begin
          result_d = '0;
          zero_d   = 1'b1;
          carry_d  = 1'b0;
        end else begin
          result_d = alu_result;
          zero_d   = (alu_result == '0);
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            carry_d = carry_q | alu_carry;
          end
        end
        if (remain_q > RPT_ONE) begin
          remain_d = remain_q - RPT_ONE;
          wait_d   = WAIT_INIT;
          state_d  = S_EXEC;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and status are decoded from the next state so they line up
    // exactly with the state they describe, without combinational outputs.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    acc_load_d  = (state_d == S_WRITE) && (op_q != OP_CLR);
    acc_clear_d = (state_d == S_WRITE) && (op_q == OP_CLR);
  end

  // State and output registers; reset abandons any command without a strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      opnd_q      <= '0;
      remain_q    <= '0;
      wait_q      <= '0;
      cmd_ready_q <= 1'b0;
      acc_load_q  <= 1'b0;
      acc_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      remain_q    <= remain_d;
      wait_q      <= wait_d;
      cmd_ready_q <= cmd_ready_d;
      acc_load_q  <= acc_load_d;
      acc_clear_q <= acc_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_op    = op_q;
  assign alu_opnd  = opnd_q;
  assign acc_load  = acc_load_q;
  assign acc_clear = acc_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
`timescale 1ns/1ps
// Bench for acc_seq_ctrl: directed table, reset/back-to-back sequences,
// random commands against a transaction-level model, and a CLR check on a
// second instance with a 3-cycle ALU latency.
module tb_acc_seq_ctrl;
  localparam int AW  = 1;
  localparam int AW3 = 3;
  localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, CLR = 3'd7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // main instance (ALU_WAIT = 1)
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0, alu_op;
  logic [7:0] cmd_data = '0, alu_opnd, alu_result, result;
  logic [3:0] cmd_repeat = '0;
  logic       alu_carry, acc_load, acc_clear, busy, done, zero, carry;
  logic [7:0] acc;

  // second instance (ALU_WAIT = 3)
  logic       cmd_valid_3 = 1'b0, cmd_ready_3;
  logic [2:0] cmd_op_3 = '0, alu_op_3;
  logic [7:0] cmd_data_3 = '0, alu_opnd_3, alu_result_3, result_3;
  logic [3:0] cmd_repeat_3 = '0;
  logic       alu_carry_3, acc_load_3, acc_clear_3, busy_3, done_3, zero_3, carry_3;
  logic [7:0] acc_3;

  acc_seq_ctrl #(.WIDTH(8), .ALU_WAIT(AW), .RPT_W(4)) u_dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_repeat(cmd_repeat),
    .alu_op(alu_op), .alu_opnd(alu_opnd), .alu_result(alu_result), .alu_carry(alu_carry),
    .acc_load(acc_load), .acc_clear(acc_clear), .busy(busy), .done(done),
    .result(result), .zero(zero), .carry(carry));

  acc_seq_ctrl #(.WIDTH(8), .ALU_WAIT(AW3), .RPT_W(4)) u_dut3 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_op(cmd_op_3), .cmd_data(cmd_data_3), .cmd_repeat(cmd_repeat_3),
    .alu_op(alu_op_3), .alu_opnd(alu_opnd_3), .alu_result(alu_result_3), .alu_carry(alu_carry_3),
    .acc_load(acc_load_3), .acc_clear(acc_clear_3), .busy(busy_3), .done(done_3),
    .result(result_3), .zero(zero_3), .carry(carry_3));

  // ALU environment: result = acc OP opnd, bit 8 is carry (ADD) or borrow (SUB)
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      LDI:     return {1'b0, b};
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {1'b0, a} - {1'b0, b};
      AND_:    return {1'b0, a & b};
      OR_:     return {1'b0, a | b};
      XOR_:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_f(alu_op, acc, alu_opnd);
  always_comb {alu_carry_3, alu_result_3} = alu_f(alu_op_3, acc_3, alu_opnd_3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc <= '0;
    else if (acc_clear) acc <= '0;
    else if (acc_load) acc <= alu_result;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc_3 <= '0;
    else if (acc_clear_3) acc_3 <= '0;
    else if (acc_load_3) acc_3 <= alu_result_3;
  end

  int load_cnt = 0, done_cnt = 0;
  always @(negedge clock) begin
    if (acc_load) load_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // transaction-level reference model of the accumulator and status flags
  int m_acc = 0, m_result = 0, m_zero = 0, m_carry = 0;

  task automatic model_cmd(input int op, input int data, input int rep,
                           output int r, output int z, output int c, output int n, output int d);
    int it;
    it = (rep == 0) ? 1 : rep;
    c = 0;
    if (op == 0) begin
      n = 0;
      d = 1;
    end else begin
      for (int i = 0; i < it; i++) begin
        case (op)
          1: m_acc = data;
          2: begin if (m_acc + data > 255) c = 1; m_acc = (m_acc + data) % 256; end
          3: begin if (m_acc < data) c = 1; m_acc = (m_acc - data + 256) % 256; end
          4: m_acc = m_acc & data;
          5: m_acc = m_acc | data;
          6: m_acc = m_acc ^ data;
          default: m_acc = 0;
        endcase
      end
      n = it;
      d = it * (AW + 1) + 1;
      m_result = m_acc;
      m_zero = (m_acc == 0) ? 1 : 0;
    end
    m_carry = c;
    r = m_result;
    z = m_zero;
  endtask

  // Issue one command to the main instance and check strobes, timing and flags.
  // Offset k means "high in the k-th cycle after the accept edge".
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input logic [3:0] rep,
                         input logic [7:0] e_res, input logic e_z, input logic e_c,
                         input int e_n, input int e_done, input string tag);
    logic [63:0] lm, cm, elm, ecm;
    int d_off, wt;
    logic ovl;
    lm = '0; cm = '0; elm = '0; ecm = '0; d_off = 0; ovl = 1'b0; wt = 0;
    for (int j = 1; j <= e_n; j++) begin
      if (op == CLR) ecm |= 64'd1 << (j * (AW + 1));
      else elm |= 64'd1 << (j * (AW + 1));
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_repeat = rep;
    while (cmd_ready !== 1'b1 && wt < 20) begin @(negedge clock); wt++; end
    chk($sformatf("%s_ready", tag), 64'(cmd_ready), 64'(1));
    @(posedge clock); #1;
    for (int k = 1; k < 64 && d_off == 0; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 3'($urandom); cmd_data = 8'($urandom); cmd_repeat = 4'($urandom);
      @(negedge clock);
      if (k == 1) begin
        chk($sformatf("%s_carry_on_accept", tag), 64'(carry), 64'(0));
        chk($sformatf("%s_busy", tag), 64'(busy), 64'(1));
        if (op != NOP) begin
          chk($sformatf("%s_alu_op", tag), 64'(alu_op), 64'(op));
          chk($sformatf("%s_alu_opnd", tag), 64'(alu_opnd), 64'(data));
        end
      end
      if (acc_load) lm[k] = 1'b1;
      if (acc_clear) cm[k] = 1'b1;
      if (acc_load && acc_clear) ovl = 1'b1;
      if (done) d_off = k;
    end
    cmd_valid = 1'b0;
    chk($sformatf("%s_done_offset", tag), 64'(d_off), 64'(e_done));
    chk($sformatf("%s_load_mask", tag), lm, elm);
    chk($sformatf("%s_clear_mask", tag), cm, ecm);
    chk($sformatf("%s_overlap", tag), 64'(ovl), 64'(0));
    chk($sformatf("%s_result", tag), 64'(result), 64'(e_res));
    chk($sformatf("%s_zero", tag), 64'(zero), 64'(e_z));
    chk($sformatf("%s_carry", tag), 64'(carry), 64'(e_c));
    @(negedge clock);
    chk($sformatf("%s_ready_after", tag), 64'(cmd_ready), 64'(1));
  endtask

  // One command on the ALU_WAIT=3 instance; returns strobe masks and done offset.
  task automatic run3(input logic [2:0] op, input logic [7:0] data, input logic [3:0] rep,
                      output logic [63:0] lm, output logic [63:0] cm, output int d_off);
    int wt;
    lm = '0; cm = '0; d_off = 0; wt = 0;
    cmd_valid_3 = 1'b1; cmd_op_3 = op; cmd_data_3 = data; cmd_repeat_3 = rep;
    while (cmd_ready_3 !== 1'b1 && wt < 20) begin @(negedge clock); wt++; end
    @(posedge clock); #1;
    cmd_valid_3 = 1'b0; cmd_data_3 = 8'($urandom); cmd_op_3 = 3'($urandom);
    for (int k = 1; k < 64 && d_off == 0; k++) begin
      @(negedge clock);
      if (acc_load_3) lm[k] = 1'b1;
      if (acc_clear_3) cm[k] = 1'b1;
      if (done_3) d_off = k;
    end
    @(negedge clock);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [3:0] rep;
    logic [7:0] res;
    logic       z;
    logic       c;
    int         n;
    int         d;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int r, z, c, n, d, l0, d0, acc_n;
    logic [63:0] lm, cm;
    int d_off;
    logic [2:0] qop[3];
    logic [7:0] qd[3];

    tbl = '{
      '{LDI,  8'h05, 4'd1, 8'h05, 1'b0, 1'b0, 1, 3},
      '{ADD,  8'h03, 4'd4, 8'h11, 1'b0, 1'b0, 4, 9},
      '{LDI,  8'hF0, 4'd1, 8'hF0, 1'b0, 1'b0, 1, 3},
      '{ADD,  8'h20, 4'd1, 8'h10, 1'b0, 1'b1, 1, 3},
      '{SUB,  8'h10, 4'd1, 8'h00, 1'b1, 1'b0, 1, 3},
      '{NOP,  8'h00, 4'd0, 8'h00, 1'b1, 1'b0, 0, 1},
      '{OR_,  8'hA5, 4'd2, 8'hA5, 1'b0, 1'b0, 2, 5},
      '{ADD,  8'h80, 4'd3, 8'h25, 1'b0, 1'b1, 3, 7},
      '{SUB,  8'h30, 4'd2, 8'hC5, 1'b0, 1'b1, 2, 5},
      '{NOP,  8'h00, 4'd1, 8'hC5, 1'b0, 1'b0, 0, 1},
      '{AND_, 8'h0F, 4'd0, 8'h05, 1'b0, 1'b0, 1, 3},
      '{XOR_, 8'h05, 4'd1, 8'h00, 1'b1, 1'b0, 1, 3},
      '{LDI,  8'h33, 4'd1, 8'h33, 1'b0, 1'b0, 1, 3},
      '{CLR,  8'h99, 4'd2, 8'h00, 1'b1, 1'b0, 2, 5}
    };

    // ---- reset state and release ----
    #12;
    chk("reset_outputs", 64'({cmd_ready, alu_op, alu_opnd, acc_load, acc_clear, busy, done, result, zero, carry}), 64'(0));
    chk("reset_outputs_3", 64'({cmd_ready_3, alu_op_3, alu_opnd_3, acc_load_3, acc_clear_3, busy_3, done_3, result_3, zero_3, carry_3}), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    chk("ready_after_release", 64'(cmd_ready), 64'(1));

    // ---- reset held 35 ns in the middle of an ADD's EXEC ----
    l0 = load_cnt;
    cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 8'h03; cmd_repeat = 4'd4;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("midexec_busy", 64'(busy), 64'(1));
    chk("midexec_no_load", 64'(acc_load), 64'(0));
    #2 reset = 1'b0;
    #1 chk("inreset_outputs", 64'({cmd_ready, alu_op, alu_opnd, acc_load, acc_clear, busy, done, result, zero, carry}), 64'(0));
    #34 reset = 1'b1;
    @(negedge clock);
    chk("postreset_outputs", 64'({cmd_ready, alu_op, alu_opnd, acc_load, acc_clear, busy, done, result, zero, carry}), 64'(0));
    @(negedge clock);
    chk("postreset_ready", 64'(cmd_ready), 64'(1));
    chk("reset_no_load", 64'(load_cnt - l0), 64'(0));
    m_acc = 0; m_result = 0; m_zero = 0; m_carry = 0;

    // ---- directed table ----
    for (int i = 0; i < 14; i++) begin
      model_cmd(int'(tbl[i].op), int'(tbl[i].data), int'(tbl[i].rep), r, z, c, n, d);
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].rep, tbl[i].res, tbl[i].z, tbl[i].c,
              tbl[i].n, tbl[i].d, $sformatf("vec%0d", i));
    end

    // ---- random commands against the model ----
    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      logic [7:0] dat;
      logic [3:0] rep;
      op = 3'($urandom_range(0, 7));
      dat = 8'($urandom);
      rep = 4'($urandom_range(0, 15));
      model_cmd(int'(op), int'(dat), int'(rep), r, z, c, n, d);
      run_cmd(op, dat, rep, 8'(r), 1'(z), 1'(c), n, d, $sformatf("rnd%0d", i));
    end

    // ---- back-to-back: valid held high, junk on the bus while not ready ----
    qop[0] = NOP;  qd[0] = 8'h11;
    qop[1] = LDI;  qd[1] = 8'h7F;
    qop[2] = XOR_; qd[2] = 8'hFF;
    acc_n = 0; d0 = done_cnt; l0 = load_cnt;
    cmd_valid = 1'b1;
    for (int cy = 0; cy < 60 && acc_n < 3; cy++) begin
      if (cmd_ready === 1'b1) begin
        cmd_op = qop[acc_n]; cmd_data = qd[acc_n]; cmd_repeat = 4'd1;
        acc_n++;
      end else begin
        cmd_op = 3'($urandom); cmd_data = 8'($urandom); cmd_repeat = 4'($urandom);
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    for (int cy = 0; cy < 20 && done_cnt < d0 + 3; cy++) @(negedge clock);
    repeat (3) @(negedge clock);
    chk("b2b_accepts", 64'(acc_n), 64'(3));
    chk("b2b_dones", 64'(done_cnt - d0), 64'(3));
    chk("b2b_loads", 64'(load_cnt - l0), 64'(2));
    chk("b2b_result", 64'(result), 64'(8'h80));
    chk("b2b_zero", 64'(zero), 64'(0));
    chk("b2b_carry", 64'(carry), 64'(0));

    // ---- ALU_WAIT = 3 instance: LDI then CLR ----
    run3(LDI, 8'h42, 4'd1, lm, cm, d_off);
    chk("w3_ldi_load_mask", lm, 64'd1 << (AW3 + 1));
    chk("w3_ldi_done", 64'(d_off), 64'(AW3 + 2));
    chk("w3_ldi_result", 64'(result_3), 64'(8'h42));
    run3(CLR, 8'h99, 4'd1, lm, cm, d_off);
    chk("w3_clr_clear_mask", cm, 64'd1 << (AW3 + 1));
    chk("w3_clr_load_mask", lm, 64'(0));
    chk("w3_clr_done", 64'(d_off), 64'(AW3 + 2));
    chk("w3_clr_result", 64'(result_3), 64'(0));
    chk("w3_clr_zero", 64'(zero_3), 64'(1));
    chk("w3_clr_carry", 64'(carry_3), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
